ps2_key_display: RTL and testbench

Receives PS/2 keyboard frames on the board's ps2_clk/ps2_data pins, tracks make/break codes and drives six active-low 7-segment digits. Digits show the held key's scan code, its ASCII code and a decimal press counter. It is the input-side counterpart of the segment-display timer: the same clock domain, reset style and segment encoding, fed by keystrokes instead of a time base.

---
 rtl/ps2_key_display_pkg.sv | 47 ++++
 rtl/ps2_key_display_rx.sv | 68 ++++++
 rtl/ps2_key_display.sv | 118 +++++++++++
 tb/tb_ps2_key_display.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_display_pkg.sv
// rtl/ps2_key_display_pkg.sv - shared segment codes, scan-code constants, key FSM state and ASCII lookup
package ps2_key_display_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low a..g in bits 7:1, dp (bit 0) held at 0.
  localparam logic [7:0] SEG_HEX [16] = '{
    8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98, 8'h48, 8'h40, 8'h1E,
    8'h00, 8'h18, 8'h10, 8'hC0, 8'h62, 8'h84, 8'h60, 8'h70
  };

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  typedef enum logic {
    ST_IDLE,
    ST_BREAK
  } key_state_t;

  function automatic logic [7:0] hex_seg(input logic [3:0] i_nibble);
    return SEG_HEX[i_nibble];
  endfunction

  // Set-2 scan code to ASCII; 8'h00 marks an unmapped key.
  function automatic logic [7:0] scan_to_ascii(input logic [7:0] i_code);
    logic [7:0] r_ascii;
    r_ascii = 8'h00;
    case (i_code)
      8'h1C: r_ascii = 8'h41;  8'h32: r_ascii = 8'h42;  8'h21: r_ascii = 8'h43;
      8'h23: r_ascii = 8'h44;  8'h24: r_ascii = 8'h45;  8'h2B: r_ascii = 8'h46;
      8'h34: r_ascii = 8'h47;  8'h33: r_ascii = 8'h48;  8'h43: r_ascii = 8'h49;
      8'h3B: r_ascii = 8'h4A;  8'h42: r_ascii = 8'h4B;  8'h4B: r_ascii = 8'h4C;
      8'h3A: r_ascii = 8'h4D;  8'h31: r_ascii = 8'h4E;  8'h44: r_ascii = 8'h4F;
      8'h4D: r_ascii = 8'h50;  8'h15: r_ascii = 8'h51;  8'h2D: r_ascii = 8'h52;
      8'h1B: r_ascii = 8'h53;  8'h2C: r_ascii = 8'h54;  8'h3C: r_ascii = 8'h55;
      8'h2A: r_ascii = 8'h56;  8'h1D: r_ascii = 8'h57;  8'h22: r_ascii = 8'h58;
      8'h35: r_ascii = 8'h59;  8'h1A: r_ascii = 8'h5A;
      8'h45: r_ascii = 8'h30;  8'h16: r_ascii = 8'h31;  8'h1E: r_ascii = 8'h32;
      8'h26: r_ascii = 8'h33;  8'h25: r_ascii = 8'h34;  8'h2E: r_ascii = 8'h35;
      8'h36: r_ascii = 8'h36;  8'h3D: r_ascii = 8'h37;  8'h3E: r_ascii = 8'h38;
      8'h46: r_ascii = 8'h39;
      default: r_ascii = 8'h00;
    endcase
    return r_ascii;
  endfunction

endpackage

// File: rtl/ps2_key_display_rx.sv
// rtl/ps2_key_display_rx.sv - PS/2 frame receiver (module ps2_rx): sync, edge detect, shift, framing check, timeout
module ps2_rx #(
  parameter int TIMEOUT = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic [2:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_shift;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          w_fall;
  logic          w_frame_ok;

  assign w_fall = r_clk_sync[2] & ~r_clk_sync[1];
  // r_shift[0] = start, [8:1] = data, [9] = parity; the live sample is the stop bit.
  assign w_frame_ok = ~r_shift[0] & r_data_sync[1] & (^r_shift[9:1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 2'b11;
      r_bit_cnt   <= 4'd0;
      r_shift     <= 10'd0;
      r_to_cnt    <= '0;
      r_data      <= 8'd0;
      r_valid     <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_valid     <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          r_valid   <= w_frame_ok;
          r_data    <= r_shift[8:1];
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_shift   <= {r_data_sync[1], r_shift[9:1]};
        end
      end else if (r_bit_cnt != 4'd0) begin
        if (r_to_cnt == TW'(TIMEOUT - 1)) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ps2_key_display.sv
// rtl/ps2_key_display.sv - PS/2 key tracker driving six 7-segment digits; PS2_ASCII_EN adds the ASCII digits
module ps2_key_display
  import ps2_key_display_pkg::*;
#(
  parameter int TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic       light
);

  logic [7:0] w_rx_data;
  logic       w_rx_valid;

  key_state_t r_state, w_state_next;
  logic [7:0] r_held, w_held_next;
  logic       r_light, w_light_next;
  logic [6:0] r_count, w_count_next;
  logic [7:0] r_seg0, r_seg1, r_seg2, r_seg3, r_seg4, r_seg5;
  logic [7:0] w_seg0, w_seg1, w_seg2, w_seg3, w_seg4, w_seg5;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_ps2_clk  (ps2_clk),
    .i_ps2_data (ps2_data),
    .o_data     (w_rx_data),
    .o_valid    (w_rx_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_held_next  = r_held;
    w_light_next = r_light;
    w_count_next = r_count;
    if (w_rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rx_data == BREAK_CODE) begin
            w_state_next = ST_BREAK;
          end else if (w_rx_data != EXT_CODE && (!r_light || w_rx_data != r_held)) begin
            // A repeat of the held key is typematic and does not count as a press.
            w_held_next  = w_rx_data;
            w_light_next = 1'b1;
            w_count_next = (r_count == 7'd99) ? 7'd0 : r_count + 7'd1;
          end
        end
        ST_BREAK: begin
          w_state_next = ST_IDLE;
          if (w_rx_data == r_held) w_light_next = 1'b0;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_seg0 = w_light_next ? hex_seg(w_held_next[3:0]) : SEG_BLANK;
    w_seg1 = w_light_next ? hex_seg(w_held_next[7:4]) : SEG_BLANK;
    w_seg4 = hex_seg(4'(w_count_next % 7'd10));
    w_seg5 = hex_seg(4'(w_count_next / 7'd10));
`ifdef PS2_ASCII_EN
    if (w_light_next && scan_to_ascii(w_held_next) != 8'h00) begin
      w_seg2 = hex_seg(scan_to_ascii(w_held_next) & 8'h0F);
      w_seg3 = hex_seg(scan_to_ascii(w_held_next) >> 4);
    end else begin
      w_seg2 = SEG_BLANK;
      w_seg3 = SEG_BLANK;
    end
`else
    w_seg2 = SEG_BLANK;
    w_seg3 = SEG_BLANK;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_held  <= 8'd0;
      r_light <= 1'b0;
      r_count <= 7'd0;
      r_seg0  <= SEG_BLANK;
      r_seg1  <= SEG_BLANK;
      r_seg2  <= SEG_BLANK;
      r_seg3  <= SEG_BLANK;
      r_seg4  <= hex_seg(4'd0);
      r_seg5  <= hex_seg(4'd0);
    end else begin
      r_state <= w_state_next;
      r_held  <= w_held_next;
      r_light <= w_light_next;
      r_count <= w_count_next;
      r_seg0  <= w_seg0;
      r_seg1  <= w_seg1;
      r_seg2  <= w_seg2;
      r_seg3  <= w_seg3;
      r_seg4  <= w_seg4;
      r_seg5  <= w_seg5;
    end
  end

  assign seg0  = r_seg0;
  assign seg1  = r_seg1;
  assign seg2  = r_seg2;
  assign seg3  = r_seg3;
  assign seg4  = r_seg4;
  assign seg5  = r_seg5;
  assign light = r_light;

endmodule

// File: tb/tb_ps2_key_display.sv
// tb/tb_ps2_key_display.sv - directed bench for ps2_key_display
module tb_ps2_key_display;

  localparam int HALF = 5;
  localparam int GAP  = 20;
  localparam logic [7:0] HEX [16] = '{
    8'h02, 8'h9E, 8'h24, 8'h0C, 8'h98, 8'h48, 8'h40, 8'h1E,
    8'h00, 8'h18, 8'h10, 8'hC0, 8'h62, 8'h84, 8'h60, 8'h70
  };
`ifdef PS2_ASCII_EN
  localparam logic [15:0] ASC_1C = {8'h98, 8'h9E};
  localparam logic [15:0] ASC_16 = {8'h0C, 8'h9E};
`else
  localparam logic [15:0] ASC_1C = 16'hFFFF;
  localparam logic [15:0] ASC_16 = 16'hFFFF;
`endif
  localparam logic [48:0] RESET_VEC = {8'h02, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic light;
  logic [48:0] w_obs;
  int n_checks = 0;
  int n_pass = 0;

  assign w_obs = {seg5, seg4, seg3, seg2, seg1, seg0, light};

  ps2_key_display dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3),
    .seg4(seg4), .seg5(seg5), .light(light)
  );

  always #10 clk = ~clk;

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int b = 0; b < n; b++) begin
      ps2_data = f[b];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad);
    logic p;
    p = (~^d) ^ bad;
    send_bits({1'b1, p, d, 1'b0}, 11);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (w_obs !== RESET_VEC) $display("FAIL reset got %h exp %h", w_obs, RESET_VEC);
    else n_pass++;
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make;
    logic [48:0] exp_v;
    exp_v = {8'h02, 8'h9E, ASC_1C, 8'h9E, 8'h62, 1'b1};
    send_byte(8'h1C, 1'b0);
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL make_1c got %h exp %h", w_obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_typematic;
    logic [48:0] exp_v;
    exp_v = {8'h02, 8'h9E, ASC_1C, 8'h9E, 8'h62, 1'b1};
    for (int i = 0; i < 3; i++) begin
      send_byte(8'h1C, 1'b0);
      n_checks++;
      if (w_obs !== exp_v) $display("FAIL typematic_%0d got %h exp %h", i, w_obs, exp_v);
      else n_pass++;
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    exp_v = {8'h02, 8'h9E, 32'hFFFF_FFFF, 1'b0};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL break_1c got %h exp %h", w_obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_parity_and_break_other;
    logic [48:0] exp_v;
    send_byte(8'h1C, 1'b1);
    exp_v = {8'h02, 8'h9E, 32'hFFFF_FFFF, 1'b0};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL bad_parity got %h exp %h", w_obs, exp_v);
    else n_pass++;
    send_byte(8'h16, 1'b0);
    exp_v = {8'h02, 8'h24, ASC_16, 8'h9E, 8'h40, 1'b1};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL make_16 got %h exp %h", w_obs, exp_v);
    else n_pass++;
    send_byte(8'hE0, 1'b0);
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL ext_prefix got %h exp %h", w_obs, exp_v);
    else n_pass++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL break_other got %h exp %h", w_obs, exp_v);
    else n_pass++;
    send_byte(8'hF0, 1'b0);
    send_byte(8'h16, 1'b0);
    exp_v = {8'h02, 8'h24, 32'hFFFF_FFFF, 1'b0};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL break_16 got %h exp %h", w_obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_count_wrap;
    int cnt;
    logic [7:0] key;
    logic [15:0] exp_c;
    cnt = 2;
    for (int i = 0; i < 98; i++) begin
      key = (i % 2 == 0) ? 8'h1C : 8'h32;
      send_byte(key, 1'b0);
      cnt = (cnt + 1) % 100;
      exp_c = {HEX[cnt / 10], HEX[cnt % 10]};
      n_checks++;
      if ({seg5, seg4, light} !== {exp_c, 1'b1})
        $display("FAIL count_%0d got %h exp %h", i, {seg5, seg4, light}, {exp_c, 1'b1});
      else n_pass++;
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h32, 1'b0);
    n_checks++;
    if (w_obs !== RESET_VEC) $display("FAIL wrap_release got %h exp %h", w_obs, RESET_VEC);
    else n_pass++;
  endtask

  task automatic test_timeout;
    logic [48:0] exp_v;
    send_bits({1'b1, 1'b0, 8'h16, 1'b0}, 5);
    repeat (52000) @(negedge clk);
    send_byte(8'h1C, 1'b0);
    exp_v = {8'h02, 8'h9E, ASC_1C, 8'h9E, 8'h62, 1'b1};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL timeout_realign got %h exp %h", w_obs, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset_midframe;
    logic [48:0] exp_v;
    send_bits({1'b1, 1'b0, 8'h32, 1'b0}, 4);
    rst = 1'b0;
    #1;
    n_checks++;
    if (w_obs !== RESET_VEC) $display("FAIL reset_async got %h exp %h", w_obs, RESET_VEC);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_byte(8'h16, 1'b0);
    exp_v = {8'h02, 8'h9E, ASC_16, 8'h9E, 8'h40, 1'b1};
    n_checks++;
    if (w_obs !== exp_v) $display("FAIL after_reset got %h exp %h", w_obs, exp_v);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_make;
    test_typematic;
    test_parity_and_break_other;
    test_count_wrap;
    test_timeout;
    test_reset_midframe;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
